// File: rtl/accum_cmd_sequencer.sv
// Command FIFO and replay sequencer that drives the 8-bit accumulator's B/S/E/clear inputs.
// Outputs change on posedge CLK; the accumulator captures them on the following negedge.
module accum_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic          cmd_s,
    input  logic [2:0]    cmd_rep,
    input  logic [7:0]    cmd_b,
    output logic [7:0]    B,
    output logic          S,
    output logic          E,
    output logic          acc_clr,
    output logic          busy,
    output logic [LW-1:0] level
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0] op;
        logic       s;
        logic [2:0] rep;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CLRQ,
        ST_NOPS
    } state_t;

    cmd_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    state_t          state_q, state_d;
    logic [2:0]      rcnt_q, rcnt_d;
    logic [7:0]      b_q, b_d;
    logic            s_q, s_d;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            finishing;
    cmd_t            head;
    cmd_t            cmd_in;

    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign push   = cmd_valid && !full;
    assign head   = mem_q[rd_ptr_q];
    assign cmd_in = '{op: cmd_op, s: cmd_s, rep: cmd_rep, b: cmd_b};

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // The head is taken on the same edge the current op ends, so ops run back to back.
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        b_d       = b_q;
        s_d       = s_q;
        pop       = 1'b0;
        finishing = ((state_q == ST_RUN) && (rcnt_q == 3'd0)) ||
                    (state_q == ST_CLRQ) || (state_q == ST_NOPS);
        if ((state_q == ST_IDLE) || finishing) begin
            if (!empty) begin
                pop = 1'b1;
                case (head.op)
                    2'b01: begin
                        state_d = ST_RUN;
                        rcnt_d  = head.rep;
                        b_d     = head.b;
                        s_d     = head.s;
                    end
                    2'b10:   state_d = ST_CLRQ;
                    default: state_d = ST_NOPS;
                endcase
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            rcnt_d = rcnt_q - 3'd1;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_IDLE;
            rcnt_q   <= 3'd0;
            b_q      <= 8'd0;
            s_q      <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            b_q      <= b_d;
            s_q      <= s_d;
        end
    end

    assign cmd_ready = !full;
    assign B         = b_q;
    assign S         = s_q;
    assign E         = (state_q == ST_RUN);
    assign acc_clr   = (state_q == ST_CLRQ);
    assign busy      = (state_q != ST_IDLE) || !empty;
    assign level     = level_q;

endmodule

// File: tb/tb_accum_cmd_sequencer.sv
// Directed plus random stimulus against a queue-based model of the command sequencer.
module tb_accum_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          CLK;
    logic          CLR;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_s;
    logic [2:0]    cmd_rep;
    logic [7:0]    cmd_b;
    logic [7:0]    B;
    logic          S;
    logic          E;
    logic          acc_clr;
    logic          busy;
    logic [LW-1:0] level;

    accum_cmd_sequencer #(.DEPTH(DEPTH), .LW(LW)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_s     (cmd_s),
        .cmd_rep   (cmd_rep),
        .cmd_b     (cmd_b),
        .B         (B),
        .S         (S),
        .E         (E),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .level     (level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] op;
        logic       s;
        logic [2:0] rep;
        logic [7:0] b;
    } cmd_t;

    // One entry per accumulator cycle still to be played: kind 1 issue, 2 clear, 0 idle slot.
    typedef struct {
        int         kind;
        logic       s;
        logic [7:0] b;
    } slot_t;

    cmd_t  cmdq[$];
    slot_t sched[$];
    logic       exp_e, exp_clr, exp_s;
    logic [7:0] exp_b;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        chk("E",       8'(E),         8'(exp_e));
        chk("acc_clr", 8'(acc_clr),   8'(exp_clr));
        chk("B",       B,             exp_b);
        chk("S",       8'(S),         8'(exp_s));
        chk("level",   8'(level),     8'(cmdq.size()));
        chk("ready",   8'(cmd_ready), 8'(cmdq.size() < DEPTH));
        chk("busy",    8'(busy),      8'((sched.size() > 0) || (cmdq.size() > 0)));
    endtask

    task automatic model_reset();
        cmdq.delete();
        sched.delete();
        exp_e   = 1'b0;
        exp_clr = 1'b0;
        exp_s   = 1'b0;
        exp_b   = 8'd0;
    endtask

    task automatic model_edge(input logic v, input cmd_t c);
        bit   was_full;
        cmd_t h;
        was_full = (cmdq.size() == DEPTH);
        if (sched.size() > 0) void'(sched.pop_front());
        if (sched.size() == 0 && cmdq.size() > 0) begin
            h = cmdq.pop_front();
            if (h.op == 2'b01) begin
                for (int i = 0; i <= int'(h.rep); i++) sched.push_back('{1, h.s, h.b});
            end else if (h.op == 2'b10) begin
                sched.push_back('{2, 1'b0, 8'd0});
            end else begin
                sched.push_back('{0, 1'b0, 8'd0});
            end
        end
        if (v && !was_full) cmdq.push_back(c);
        exp_e   = 1'b0;
        exp_clr = 1'b0;
        if (sched.size() > 0) begin
            if (sched[0].kind == 1) begin
                exp_e = 1'b1;
                exp_b = sched[0].b;
                exp_s = sched[0].s;
            end else if (sched[0].kind == 2) begin
                exp_clr = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] op, input logic s,
                         input logic [2:0] rep, input logic [7:0] b);
        cmd_t c;
        cmd_valid = v;
        cmd_op    = op;
        cmd_s     = s;
        cmd_rep   = rep;
        cmd_b     = b;
        c = '{op, s, rep, b};
        @(posedge CLK);
        model_edge(v, c);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b0, 3'd0, 8'd0);
    endtask

    initial begin
        CLR       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_s     = 1'b0;
        cmd_rep   = 3'd0;
        cmd_b     = 8'd0;
        model_reset();
        #12;
        check_all();
        CLR = 1'b0;
        idle(2);

        // single issue, rep 0
        cycle(1'b1, 2'b01, 1'b0, 3'd0, 8'h05);
        idle(3);

        // repeat then clear then issue, back to back
        cycle(1'b1, 2'b01, 1'b0, 3'd2, 8'h01);
        cycle(1'b1, 2'b10, 1'b0, 3'd0, 8'hEE);
        cycle(1'b1, 2'b01, 1'b1, 3'd0, 8'h02);
        idle(7);

        // long head holds the FIFO; the fifth follow-up push must be dropped
        cycle(1'b1, 2'b01, 1'b0, 3'd7, 8'hA0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'b01, i[0], 3'd1, 8'hB0 + 8'(i));
        idle(20);

        // pointer wrap with continuous valid
        for (int i = 0; i < 10; i++) cycle(1'b1, 2'b01, 1'b0, 3'd0, 8'(i));
        idle(6);

        // reserved op between two issues
        cycle(1'b1, 2'b01, 1'b1, 3'd0, 8'h11);
        cycle(1'b1, 2'b11, 1'b0, 3'd0, 8'h00);
        cycle(1'b1, 2'b01, 1'b0, 3'd0, 8'h22);
        idle(5);

        // asynchronous reset in the middle of a repeated issue
        cycle(1'b1, 2'b01, 1'b1, 3'd5, 8'h33);
        cycle(1'b1, 2'b10, 1'b0, 3'd0, 8'h00);
        idle(1);
        CLR = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        CLR = 1'b0;
        idle(4);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
                  3'($urandom_range(0, 3)), 8'($urandom));
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
